// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer and instruction memory.
//   fetch_valid / fetch_addr : request from the sequencer
//   fetch_ready              : memory accepts the request when valid & ready
//   rsp_valid / rsp_instr    : single-cycle response strobe and data
// master = sequencer side, slave = memory side.
interface pc_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_instr;

  modport master (
    output fetch_valid, fetch_addr,
    input  fetch_ready, rsp_valid, rsp_instr
  );

  modport slave (
    input  fetch_valid, fetch_addr,
    output fetch_ready, rsp_valid, rsp_instr
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer. Issues one fetch at a
// time for the current PC, waits for its response and hands the instruction and
// its PC to decode. Branch redirects replace the PC; a response belonging to a
// request issued before a redirect is dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               suppresses new fetch requests
//   br_valid, br_target one-cycle redirect strobe and its target address
//   bus                 fetch request/response bus (master side)
//   instr_valid         one-cycle strobe for a delivered instruction
//   instr, instr_pc     delivered instruction and its PC
//   instr_count         delivered-instruction count, wraps modulo 2^32
//
// state  | meaning
// S_RST  | just reset, no request yet; always moves to S_REQ next cycle
// S_REQ  | presenting a fetch for pc (unless stalled)
// S_WAIT | one request outstanding, waiting for its response
module pc_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] STEP     = ADDR_W'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_valid,
  input  logic [ADDR_W-1:0]   br_target,
  pc_fetch_sequencer_if.master bus,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              squash;  // outstanding response is stale (redirect since issue)
  logic              handshake;

  // Valid is allowed to drop with stall; there is no hold requirement on it.
  assign bus.fetch_valid = (state == S_REQ) && !stall;
  assign bus.fetch_addr  = pc;
  assign handshake       = bus.fetch_valid && bus.fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_count <= '0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        S_RST: state <= S_REQ;
        S_REQ: begin
          // A redirect coinciding with the handshake still issues the old pc,
          // so its response must be discarded.
          if (handshake) begin
            state  <= S_WAIT;
            squash <= br_valid;
          end
          if (br_valid) pc <= br_target;
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            state  <= S_REQ;
            squash <= 1'b0;
            if (br_valid) begin
              pc <= br_target;
            end else if (!squash) begin
              instr_valid <= 1'b1;
              instr       <= bus.rsp_instr;
              instr_pc    <= pc;
              pc          <= pc + STEP;
              instr_count <= instr_count + 32'd1;
            end
          end else if (br_valid) begin
            pc     <= br_target;
            squash <= 1'b1;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  localparam int unsigned AW = 32;
  localparam logic [31:0] K  = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br_valid;
  logic [31:0] br_target;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, instr_count;

  pc_fetch_sequencer_if #(.ADDR_W(AW)) bus ();

  pc_fetch_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0), .STEP(32'h1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .bus(bus), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_count(instr_count)
  );

  // Second instance: reset PC near the top of the address space, 1-cycle memory.
  pc_fetch_sequencer_if #(.ADDR_W(AW)) wbus ();
  logic        w_iv;
  logic [31:0] w_instr, w_pc, w_cnt;
  logic        w_pend;
  logic [31:0] w_data;
  logic [31:0] w_q[$];

  pc_fetch_sequencer #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFE), .STEP(32'h1)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .br_valid(1'b0), .br_target(32'h0),
    .bus(wbus), .instr_valid(w_iv), .instr(w_instr), .instr_pc(w_pc),
    .instr_count(w_cnt)
  );

  initial begin
    wbus.fetch_ready = 1'b1;
    wbus.rsp_valid   = 1'b0;
    wbus.rsp_instr   = '0;
    w_pend           = 1'b0;
    w_data           = '0;
  end

  // Responds in the cycle after each handshake.
  always @(negedge clk) begin
    if (rst) begin
      wbus.rsp_valid = 1'b0;
      w_pend         = 1'b0;
    end else begin
      wbus.rsp_valid = w_pend;
      wbus.rsp_instr = w_data;
      w_pend         = wbus.fetch_valid;
      w_data         = wbus.fetch_addr ^ K;
    end
    if (w_iv && w_q.size() < 3) w_q.push_back(w_pc);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural pc, whether a request is in flight and
  // whether that request has been overtaken by a redirect.
  logic [31:0] m_pc, m_req, m_instr, m_ipc, m_cnt;
  logic        m_boot, m_out, m_stale, m_iv, exp_fv;

  task automatic model_reset();
    m_pc = 32'h0; m_req = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_boot = 1'b1;
    m_iv = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
  endtask

  // Memory for the main instance: variable latency, optional idle-time noise.
  logic        mem_pend;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_addr;
  logic        spur_en;

  logic        hs_seen, iv_seen;
  logic [31:0] hs_addr, iv_pc, iv_instr;

  task automatic cycle();
    logic from_mem;
    logic hs;
    from_mem      = 1'b0;
    bus.rsp_valid = 1'b0;
    if (mem_pend && mem_cnt == 0) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_instr = mem_addr ^ K;
      from_mem      = 1'b1;
    end else if (!mem_pend && spur_en && $urandom_range(0, 5) == 0) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_instr = $urandom;
    end
    #1;
    exp_fv = !m_boot && !m_out && !stall;
    chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, exp_fv});
    if (exp_fv) chk("fetch_addr", bus.fetch_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_iv});
    if (m_iv) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
    chk("instr_count", instr_count, m_cnt);
    if (instr_valid) begin
      iv_seen = 1'b1; iv_pc = instr_pc; iv_instr = instr;
    end
    hs = bus.fetch_valid && bus.fetch_ready;
    if (hs) begin
      hs_seen = 1'b1; hs_addr = bus.fetch_addr;
    end
    if (from_mem) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (hs) begin
      mem_pend = 1'b1; mem_addr = bus.fetch_addr; mem_cnt = mem_lat - 1;
    end
    // model step for the coming edge
    if (rst) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 1'b0; m_iv = 1'b0;
    end else if (!m_out) begin
      m_iv = 1'b0;
      if (exp_fv && bus.fetch_ready) begin
        m_out = 1'b1; m_stale = br_valid; m_req = m_pc;
      end
      if (br_valid) m_pc = br_target;
    end else begin
      m_iv = 1'b0;
      if (bus.rsp_valid) begin
        if (br_valid) m_pc = br_target;
        else if (!m_stale) begin
          m_iv = 1'b1; m_instr = m_req ^ K; m_ipc = m_pc;
          m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
        end
        m_out = 1'b0; m_stale = 1'b0;
      end else if (br_valid) begin
        m_pc = br_target; m_stale = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_hs(input int maxc, input string what);
    hs_seen = 1'b0;
    for (int i = 0; i < maxc && !hs_seen; i++) cycle();
    if (!hs_seen) begin
      checks++; errors++;
      $display("FAIL timeout %s: no handshake within %0d cycles", what, maxc);
    end
  endtask

  task automatic run_until_iv(input int maxc, input string what);
    iv_seen = 1'b0;
    for (int i = 0; i < maxc && !iv_seen; i++) cycle();
    if (!iv_seen) begin
      checks++; errors++;
      $display("FAIL timeout %s: no instr_valid within %0d cycles", what, maxc);
    end
  endtask

  // Wait for the idle request state, then redirect while stalled (no handshake).
  task automatic redirect_to(input logic [31:0] addr);
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 20 && (m_boot || m_out); i++) cycle();
    if (m_boot || m_out) begin
      checks++; errors++;
      $display("FAIL timeout redirect: sequencer busy, got busy expected idle");
    end
    stall = 1'b1; br_valid = 1'b1; br_target = addr;
    cycle();
    br_valid = 1'b0;
  endtask

  logic [31:0] wexp[3];

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    bus.fetch_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_instr = '0;
    mem_pend = 1'b0; mem_cnt = 0; mem_lat = 2; mem_addr = '0; spur_en = 1'b0;
    hs_seen = 1'b0; iv_seen = 1'b0; hs_addr = '0; iv_pc = '0; iv_instr = '0;
    wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0000_0000;

    // reset held for three edges
    @(posedge clk); #1;
    model_reset();
    cycle(); cycle();
    chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr_count", instr_count, 32'h0);
    rst = 1'b0; #1;
    chk("boot_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    cycle();
    chk("first_fetch_valid", {31'b0, bus.fetch_valid}, 32'h1);
    chk("first_fetch_addr", bus.fetch_addr, 32'h0);

    // 100 sequential fetches, 2-cycle memory
    bus.fetch_ready = 1'b1; mem_lat = 2;
    for (int i = 0; i < 100; i++) begin
      run_until_iv(20, "seq");
      chk("seq_pc", iv_pc, i);
      chk("seq_instr", iv_instr, i ^ K);
    end
    chk("seq_count", instr_count, 32'd100);

    // redirect while waiting on pc 5
    redirect_to(32'h5);
    stall = 1'b0; bus.fetch_ready = 1'b1;
    run_until_hs(10, "pc5");
    chk("wait_hs_addr", hs_addr, 32'h5);
    br_valid = 1'b1; br_target = 32'h40;
    cycle();
    br_valid = 1'b0;
    run_until_hs(10, "after_wait_br");
    chk("wait_br_fetch", hs_addr, 32'h40);
    run_until_iv(10, "after_wait_br");
    chk("wait_br_pc", iv_pc, 32'h40);
    chk("wait_br_instr", iv_instr, 32'h40 ^ K);

    // redirect in the same cycle as the handshake at pc 7
    redirect_to(32'h7);
    stall = 1'b0; bus.fetch_ready = 1'b1; br_valid = 1'b1; br_target = 32'h80;
    hs_seen = 1'b0;
    cycle();
    br_valid = 1'b0;
    chk("hs_br_issued", hs_addr, 32'h7);
    run_until_hs(10, "after_hs_br");
    chk("hs_br_fetch", hs_addr, 32'h80);
    run_until_iv(10, "after_hs_br");
    chk("hs_br_pc", iv_pc, 32'h80);

    // stall at pc 3 for ten cycles
    redirect_to(32'h3);
    bus.fetch_ready = 1'b1; iv_seen = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("stall_no_deliver", {31'b0, iv_seen}, 32'h0);
    stall = 1'b0; #1;
    chk("unstall_valid", {31'b0, bus.fetch_valid}, 32'h1);
    chk("unstall_addr", bus.fetch_addr, 32'h3);

    // reset while waiting; the late response must be ignored
    mem_lat = 3;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; bus.fetch_ready = 1'b0; iv_seen = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("late_rsp_ignored", {31'b0, iv_seen}, 32'h0);
    chk("late_rsp_count", instr_count, 32'h0);
    bus.fetch_ready = 1'b1;
    run_until_hs(10, "refetch");
    chk("refetch_addr", hs_addr, 32'h0);

    // randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall           = ($urandom_range(0, 3) == 0);
      bus.fetch_ready = ($urandom_range(0, 9) < 7);
      br_valid        = ($urandom_range(0, 9) == 0);
      br_target       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                    : $urandom_range(0, 255);
      mem_lat         = $urandom_range(1, 3);
      cycle();
    end

    // wrap-around instance
    chk("wrap_n", w_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("wrap_pc", (i < w_q.size()) ? w_q[i] : 32'hDEAD_BEEF, wexp[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
